// File: rtl/uart_axil_pkg.sv
// uart_axil_pkg: shared constants and state encodings for the UART-to-AXI-lite bridge
package uart_axil_pkg;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  typedef enum logic [3:0] {IDLE, CMD, ADDR, DATA, WR, WB, RD, RR, RSP} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
endpackage

// File: rtl/uart_axil_serdes.sv
// uart_axil_serdes: 8-N-1 receiver with 2-flop synchroniser plus matching transmitter
module uart_axil_serdes
  import uart_axil_pkg::*;
#(
  parameter int DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       tx,
  output logic       tx_busy
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  rx_state_t rs;
  logic [2:0] rx_sync;
  logic [CW-1:0] rc, tc;
  logic [2:0] rb;
  logic [3:0] tn;
  logic [8:0] ts;
  // two synchroniser flops plus one history flop for falling-edge detection
  always_ff @(posedge clk) rx_sync <= rst ? 3'b111 : {rx_sync[1:0], rx};
  // receiver: confirm start at mid-bit, shift data LSB-first, check stop bit
  always_ff @(posedge clk)
    if (rst) begin
      rs <= R_IDLE;
      rc <= '0;
      rb <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      rc <= rc + 1'b1;
      case (rs)
        R_IDLE: begin
          rc <= '0;
          if (rx_sync[2] && !rx_sync[1]) rs <= R_START;
        end
        R_START: if (rc == HALF) begin
          rc <= '0;
          rb <= '0;
          rs <= rx_sync[1] ? R_IDLE : R_DATA;
        end
        R_DATA: if (rc == LAST) begin
          rc <= '0;
          rx_data <= {rx_sync[1], rx_data[7:1]};
          rb <= rb + 1'b1;
          if (rb == 3'd7) rs <= R_STOP;
        end
        R_STOP: if (rc == LAST) begin
          rs <= R_IDLE;
          rx_valid <= rx_sync[1];
          rx_ferr <= !rx_sync[1];
        end
        default: rs <= R_IDLE;
      endcase
    end
  // transmitter: start bit, 8 data bits, stop bit; busy covers the whole stop period
  always_ff @(posedge clk)
    if (rst) begin
      tx <= 1'b1;
      tx_busy <= 1'b0;
      ts <= '0;
      tc <= '0;
      tn <= '0;
    end else if (!tx_busy) begin
      tc <= '0;
      tn <= '0;
      if (tx_start) begin
        tx <= 1'b0;
        ts <= {1'b1, tx_data};
        tx_busy <= 1'b1;
      end
    end else if (tc == LAST) begin
      tc <= '0;
      tn <= tn + 1'b1;
      tx <= ts[0];
      ts <= {1'b1, ts[8:1]};
      if (tn == 4'd9) tx_busy <= 1'b0;
    end else tc <= tc + 1'b1;
endmodule

// File: rtl/uart_axil_master.sv
// uart_axil_master: UART command parser driving a single-outstanding AXI-lite initiator
module uart_axil_master
  import uart_axil_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        aclk,
  input  logic        areset,
  output logic [31:0] m_axi_lite_awaddr,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready,
  output logic [31:0] m_axi_lite_araddr,
  output logic        m_axi_lite_arvalid,
  input  logic        m_axi_lite_arready,
  input  logic [31:0] m_axi_lite_rdata,
  input  logic [1:0]  m_axi_lite_rresp,
  input  logic        m_axi_lite_rvalid,
  output logic        m_axi_lite_rready,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        busy
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic is_wr, rx_valid, rx_ferr, tx_busy, tx_start;
  logic [1:0] idx;
  logic [TW-1:0] tmo;
  logic [31:0] addr;
  logic [39:0] rsp_buf;
  logic [2:0] rsp_n;
  logic [7:0] rx_data, tx_byte;
  assign m_axi_lite_awaddr = addr;
  assign m_axi_lite_araddr = addr;
  assign busy = state != IDLE;
  uart_axil_serdes #(.DIV(DIV)) serdes (
    .clk(aclk), .rst(areset), .rx(uart_rx), .tx_data(tx_byte), .tx_start(tx_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr), .tx(uart_tx), .tx_busy(tx_busy)
  );
  // command parser, bus sequencing and reply queueing in one registered FSM
  always_ff @(posedge aclk)
    if (areset) begin
      state <= IDLE;
      is_wr <= 1'b0;
      idx <= '0;
      tmo <= '0;
      addr <= '0;
      m_axi_lite_wdata <= '0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wvalid <= 1'b0;
      m_axi_lite_bready <= 1'b0;
      m_axi_lite_arvalid <= 1'b0;
      m_axi_lite_rready <= 1'b0;
      rsp_buf <= '0;
      rsp_n <= '0;
      tx_byte <= '0;
      tx_start <= 1'b0;
    end else case (state)
      IDLE: if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
        is_wr <= rx_data == CMD_WR;
        state <= CMD;
      end
      CMD: begin
        idx <= '0;
        tmo <= '0;
        state <= ADDR;
      end
      ADDR, DATA: begin
        if (rx_ferr) state <= IDLE;
        else if (rx_valid) begin
          tmo <= '0;
          idx <= idx + 1'b1;
          if (state == ADDR) addr <= {rx_data, addr[31:8]};
          else m_axi_lite_wdata <= {rx_data, m_axi_lite_wdata[31:8]};
          if (idx == 2'd3) begin
            state <= state == DATA ? WR : is_wr ? DATA : RD;
            m_axi_lite_awvalid <= state == DATA;
            m_axi_lite_wvalid <= state == DATA;
            m_axi_lite_arvalid <= state == ADDR && !is_wr;
          end
        end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) state <= IDLE;
        else tmo <= tmo + 1'b1;
      end
      WR: begin
        if (m_axi_lite_awready) m_axi_lite_awvalid <= 1'b0;
        if (m_axi_lite_wready) m_axi_lite_wvalid <= 1'b0;
        if ((!m_axi_lite_awvalid || m_axi_lite_awready) && (!m_axi_lite_wvalid || m_axi_lite_wready)) begin
          m_axi_lite_bready <= 1'b1;
          state <= WB;
        end
      end
      WB: if (m_axi_lite_bvalid) begin
        m_axi_lite_bready <= 1'b0;
        rsp_buf <= {32'h0, m_axi_lite_bresp == RESP_OKAY ? RSP_OK : RSP_ERR};
        rsp_n <= 3'd1;
        state <= RSP;
      end
      RD: if (m_axi_lite_arready) begin
        m_axi_lite_arvalid <= 1'b0;
        m_axi_lite_rready <= 1'b1;
        state <= RR;
      end
      RR: if (m_axi_lite_rvalid) begin
        m_axi_lite_rready <= 1'b0;
        rsp_buf <= m_axi_lite_rresp == RESP_OKAY ? {m_axi_lite_rdata, RSP_OK} : {32'h0, RSP_ERR};
        rsp_n <= m_axi_lite_rresp == RESP_OKAY ? 3'd5 : 3'd1;
        state <= RSP;
      end
      RSP: begin
        if (tx_start) tx_start <= 1'b0;
        else if (!tx_busy) begin
          if (rsp_n == 3'd0) state <= IDLE;
          else begin
            tx_byte <= rsp_buf[7:0];
            rsp_buf <= {8'h0, rsp_buf[39:8]};
            rsp_n <= rsp_n - 3'd1;
            tx_start <= 1'b1;
          end
        end
      end
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_uart_axil_master.sv
// tb_uart_axil_master: directed vectors for the UART-to-AXI-lite bridge
module tb_uart_axil_master;
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0] resp;
    int aw_dly;
    int w_dly;
    int nrsp;
    logic [39:0] rsp;
  } vec_t;
  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] awaddr, wdata, araddr;
  logic [31:0] rdata = '0;
  logic awvalid, wvalid, bready, arvalid, rready, uart_tx, busy;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = '0, rresp = '0;
  logic uart_rx = 1'b1;
  int n_vec = 0, n_bad = 0;
  int aw_dly = 0, w_dly = 0, aw_age = 0, w_age = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [31:0] cap_aw = '0, cap_w = '0, cap_ar = '0, cur_addr = '0, cur_data = '0;
  logic [1:0] cur_resp = '0;
  bit aw_only = 0, w_only = 0, unstable = 0, any_valid = 0;
  logic [7:0] rxq[$];
  vec_t vecs[6];
  vec_t hv;

  always #5 aclk = ~aclk;

  uart_axil_master #(.CLK_FREQ(10_000_000), .BAUD_RATE(1_000_000), .TIMEOUT_CYCLES(2000)) dut (
    .aclk(aclk), .areset(areset),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
    .m_axi_lite_rready(rready), .uart_rx(uart_rx), .uart_tx(uart_tx), .busy(busy)
  );

  // responder bookkeeping: handshakes complete on the rising edge
  always @(posedge aclk) begin
    if (awvalid && awready) begin aw_hs++; cap_aw = awaddr; end
    if (wvalid && wready) begin w_hs++; cap_w = wdata; end
    if (bvalid && bready) b_hs++;
    if (arvalid && arready) begin ar_hs++; cap_ar = araddr; end
    if (rvalid && rready) r_hs++;
    aw_age = awvalid ? aw_age + 1 : 0;
    w_age = wvalid ? w_age + 1 : 0;
  end

  // responder drive and protocol observation between edges
  always @(negedge aclk) begin
    awready = awvalid && aw_age >= aw_dly;
    wready = wvalid && w_age >= w_dly;
    bvalid = bready;
    bresp = cur_resp;
    arready = arvalid;
    rvalid = rready;
    rresp = cur_resp;
    rdata = cur_data;
    if (awvalid && !wvalid) aw_only = 1;
    if (wvalid && !awvalid) w_only = 1;
    if ((awvalid && awaddr !== cur_addr) || (wvalid && wdata !== cur_data) || (arvalid && araddr !== cur_addr)) unstable = 1;
    if (awvalid || wvalid || arvalid) any_valid = 1;
  end

  // serial reply decoder, sampling each bit near its centre
  initial forever begin : tx_mon
    logic [7:0] b;
    @(negedge uart_tx);
    repeat (5) @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge aclk);
      b[i] = uart_tx;
    end
    repeat (10) @(negedge aclk);
    rxq.push_back(b);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (10) @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(negedge aclk);
    end
    uart_rx = stop;
    repeat (10) @(negedge aclk);
    uart_rx = 1'b1;
    repeat (4) @(negedge aclk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    check($sformatf("%s idle", name), 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [39:0] got = '0;
    aw_dly = v.aw_dly;
    w_dly = v.w_dly;
    cur_resp = v.resp;
    cur_addr = v.addr;
    cur_data = v.data;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_only = 0; w_only = 0; unstable = 0;
    rxq.delete();
    send_byte(v.wr ? 8'h57 : 8'h52, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8], 1'b1);
    if (v.wr) for (int i = 0; i < 4; i++) send_byte(v.data[8*i +: 8], 1'b1);
    wait_idle(name);
    for (int i = 0; i < rxq.size() && i < 5; i++) got[8*i +: 8] = rxq[i];
    check($sformatf("%s reply count", name), 64'(rxq.size()), 64'(v.nrsp));
    check($sformatf("%s reply bytes", name), 64'(got), 64'(v.rsp));
    check($sformatf("%s hold stable", name), 64'(unstable), 64'd0);
    if (v.wr) begin
      check($sformatf("%s aw count", name), 64'(aw_hs), 64'd1);
      check($sformatf("%s w count", name), 64'(w_hs), 64'd1);
      check($sformatf("%s b count", name), 64'(b_hs), 64'd1);
      check($sformatf("%s ar count", name), 64'(ar_hs), 64'd0);
      check($sformatf("%s awaddr", name), 64'(cap_aw), 64'(v.addr));
      check($sformatf("%s wdata", name), 64'(cap_w), 64'(v.data));
      check($sformatf("%s skew", name), 64'({aw_only, w_only}), 64'({v.aw_dly > v.w_dly, v.w_dly > v.aw_dly}));
    end else begin
      check($sformatf("%s ar count", name), 64'(ar_hs), 64'd1);
      check($sformatf("%s r count", name), 64'(r_hs), 64'd1);
      check($sformatf("%s aw count", name), 64'(aw_hs), 64'd0);
      check($sformatf("%s araddr", name), 64'(cap_ar), 64'(v.addr));
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0, 0, 1, 40'h4B};
    vecs[1] = '{1'b0, 32'h0000_1004, 32'h1234_5678, 2'b00, 0, 0, 5, 40'h12_34_56_78_4B};
    vecs[2] = '{1'b1, 32'h0000_2000, 32'h1122_3344, 2'b10, 0, 0, 1, 40'h45};
    vecs[3] = '{1'b0, 32'h0000_3000, 32'h9ABC_DEF0, 2'b11, 0, 0, 1, 40'h45};
    vecs[4] = '{1'b1, 32'h0000_4000, 32'hCAFE_F00D, 2'b00, 3, 0, 1, 40'h4B};
    vecs[5] = '{1'b1, 32'h0000_4004, 32'h0BAD_F00D, 2'b00, 0, 3, 1, 40'h4B};
    repeat (5) @(negedge aclk);
    check("reset ctl", 64'({awvalid, wvalid, bready, arvalid, rready, uart_tx, busy}), 64'b0000010);
    check("reset addr/data", {awaddr, wdata}, 64'd0);
    areset = 1'b0;
    repeat (5) @(negedge aclk);
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    rxq.delete();
    any_valid = 0;
    send_byte(8'h00, 1'b1);
    repeat (300) @(negedge aclk);
    check("garbage busy", 64'(busy), 64'd0);
    check("garbage reply", 64'(rxq.size()), 64'd0);
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (1000) @(negedge aclk);
    check("timeout waiting", 64'(busy), 64'd1);
    repeat (2000) @(negedge aclk);
    check("timeout busy", 64'(busy), 64'd0);
    check("timeout bus", 64'(any_valid), 64'd0);
    check("timeout reply", 64'(rxq.size()), 64'd0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
    check("framing before", 64'(busy), 64'd1);
    send_byte(8'h10, 1'b0);
    repeat (20) @(negedge aclk);
    check("framing abort", 64'(busy), 64'd0);
    check("framing bus", 64'(any_valid), 64'd0);
    hv = '{1'b0, 32'h0000_5008, 32'hA5C3_0F96, 2'b00, 0, 0, 5, 40'hA5_C3_0F_96_4B};
    run_vec(hv, "after abort");
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    uart_rx = 1'b0;
    repeat (10) @(negedge aclk);
    uart_rx = 1'b1;
    repeat (15) @(negedge aclk);
    check("mid-op busy", 64'(busy), 64'd1);
    check("mid-op awaddr", 64'(awaddr), 64'h2000);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("mid reset ctl", 64'({awvalid, wvalid, bready, arvalid, rready, uart_tx, busy}), 64'b0000010);
    check("mid reset addr/data", {awaddr, wdata}, 64'd0);
    repeat (150) @(negedge aclk);
    hv = '{1'b1, 32'h0000_6000, 32'h7654_3210, 2'b00, 1, 1, 1, 40'h4B};
    run_vec(hv, "after reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
